osc_clock_reset_gen: RTL and testbench
======================================

// Module: osc_clock_reset_gen
// PURPOSE
//   Clock/reset front end of the printer controller.
//   - Free-runs from the on-chip oscillator clock osc_clk (OSCC, nominal ~22 MHz).
//   - Divides it into a slow clock clk (fan PWM) and a fast clock clk_2 (stepper PWM).
//   - Produces a synchronised active-high reset rst for downstream blocks.
//   - Replaces the ad-hoc GSR/OSCC divider wiring at the top level.
// PARAMETERS
//   SLOW_DIV_BIT    22  counter bit driving clk; clk period = 2^(SLOW_DIV_BIT+1) osc_clk cycles
//   FAST_DIV_BIT    13  counter bit driving clk_2; clk_2 period = 2^(FAST_DIV_BIT+1) osc_clk cycles
//   RST_SYNC_STAGES  2  flops in the reset-release synchroniser (legal: >=2)
// PORTS
//   osc_clk    in   1  oscillator clock; all logic is on its rising edge
//   rstn       in   1  asynchronous active-low reset
//   clk        out  1  slow divided clock, 50% duty
//   clk_2      out  1  fast divided clock, 50% duty
//   rst        out  1  active-high reset for downstream logic
//   tick_slow  out  1  1-cycle strobe (only with CLKGEN_TICK_EN)
//   tick_fast  out  1  1-cycle strobe (only with CLKGEN_TICK_EN)
// BEHAVIOUR
//   Interface: one clock, osc_clk; reset rstn is asynchronous and active-low.
//   Counters:
//   - Two independent unsigned up-counters: c_slow [SLOW_DIV_BIT:0], c_fast [FAST_DIV_BIT:0].
//   - Each increments by 1 on every osc_clk rising edge.
//   - Each wraps from all-ones to 0 with no stall or skipped value.
//   Outputs from counters:
//   - clk   = c_slow[SLOW_DIV_BIT] and clk_2 = c_fast[FAST_DIV_BIT]; direct register bits, glitch-free.
//   - Defaults: clk toggles every 2^22 cycles, clk_2 toggles every 2^13 cycles.
//   Reset assertion (rstn=0):
//   - Takes effect immediately, with no clock required.
//   - c_slow=0, c_fast=0, clk=0, clk_2=0, rst=1, tick_*=0.
//   Reset release:
//   - rst stays 1 and deasserts synchronously to osc_clk.
//   - rst goes low on the RST_SYNC_STAGES-th osc_clk rising edge after rstn rises.
//   - Counters run from the first osc_clk edge after rstn rises.
//   Timing:
//   - First clk_2 rise: at edge 2^FAST_DIV_BIT after release (8192 by default).
//   - First clk rise: at edge 2^SLOW_DIV_BIT after release.
//   - Both clocks are low for exactly half a period after reset.
//   Reset mid-operation:
//   - Asynchronously aborts the current period; clocks drop low at once, possibly as a short high pulse.
//   - rst rises with no delay.
//   - On release the sequence restarts from count 0, identical to power-up.
//   Other rules:
//   - Short rstn glitch (< 1 cycle) is a full reset.
//   - No other inputs; no enable or stall; behaviour is fully periodic after release.
// CONFIGURATION
//   CLKGEN_TICK_EN defined:
//   - tick_fast = 1 for exactly one osc_clk cycle when c_fast wraps to 0 (once per clk_2 period).
//   - tick_slow does the same on c_slow wrap.
//   - Both strobes are registered and held 0 while rst=1.
//   - The first strobe occurs after one full period.
//   CLKGEN_TICK_EN undefined: tick_slow and tick_fast are tied to 0 and no strobe logic is built.
// TESTING
//   Sims override SLOW_DIV_BIT=4 and FAST_DIV_BIT=2.
//   1. rstn=0 for 3 cycles, then 1 -> rst=1 until 2nd edge after release, then 0;
//      clk_2 first rises at edge 4; clk first rises at edge 16.
//   2. Run 200 cycles -> clk_2 period 8 (4 high/4 low); clk period 32 (16/16); no missed wrap.
//   3. Pull rstn low mid-high-phase of clk, asynchronously between edges
//      -> clk, clk_2, counters 0 and rst=1 immediately; after release, step 1 timing repeats exactly.
//   4. CLKGEN_TICK_EN defined -> tick_fast high 1 cycle every 8 edges (first at edge 8);
//      tick_slow every 32 (first at edge 32); both 0 during reset.
//   5. Defaults (22/13), run 2^15 cycles after release -> clk_2 toggles at 8192, 16384, 24576; clk stays 0.

Source files
------------

// File: rtl/osc_clock_reset_gen.sv
// ---------------------------------------------------------------------------
// osc_clock_reset_gen
//   Clock/reset front end of the printer controller. Everything runs from the
//   on-chip oscillator osc_clk. Two free-running up-counters give a slow
//   divided clock (clk, fan PWM) and a fast divided clock (clk_2, stepper
//   PWM). The clocks are taken straight from counter register bits, so they
//   are glitch-free. A reset-release synchroniser produces rst, an
//   active-high reset for downstream logic.
//
// Parameters
//   SLOW_DIV_BIT     counter bit driving clk   (period 2^(SLOW_DIV_BIT+1))
//   FAST_DIV_BIT     counter bit driving clk_2 (period 2^(FAST_DIV_BIT+1))
//   RST_SYNC_STAGES  reset-release synchroniser depth, must be >= 2
//
// Ports
//   osc_clk    in   oscillator clock, rising edge only
//   rstn       in   asynchronous active-low reset
//   clk        out  slow divided clock, 50% duty
//   clk_2      out  fast divided clock, 50% duty
//   rst        out  active-high reset, asserted at once, released in sync
//   tick_slow  out  one-cycle strobe on c_slow wrap (CLKGEN_TICK_EN only)
//   tick_fast  out  one-cycle strobe on c_fast wrap (CLKGEN_TICK_EN only)
//
// Build option
//   CLKGEN_TICK_EN  when defined, builds the registered wrap strobes.
//                   Otherwise the strobes are tied to 0.
// ---------------------------------------------------------------------------
module osc_clock_reset_gen #(
    parameter int SLOW_DIV_BIT    = 22,
    parameter int FAST_DIV_BIT    = 13,
    parameter int RST_SYNC_STAGES = 2
) (
    input  logic osc_clk,
    input  logic rstn,
    output logic clk,
    output logic clk_2,
    output logic rst,
    output logic tick_slow,
    output logic tick_fast
);

    localparam logic [SLOW_DIV_BIT:0] SLOW_ONE = 1;
    localparam logic [FAST_DIV_BIT:0] FAST_ONE = 1;

    logic [SLOW_DIV_BIT:0]    c_slow;
    logic [FAST_DIV_BIT:0]    c_fast;
    logic [RST_SYNC_STAGES-1:0] rst_sync;

    // A zero is shifted in after release. rst follows the last stage, so it
    // falls on the RST_SYNC_STAGES-th edge after rstn rises.
    always_ff @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync <= '1;
        end else begin
            rst_sync <= {rst_sync[RST_SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst = rst_sync[RST_SYNC_STAGES-1];

    // The counters do not wait for rst. They start on the first edge after
    // release, which keeps clock phase tied to rstn and not to the
    // synchroniser depth.
    always_ff @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            c_slow <= '0;
            c_fast <= '0;
        end else begin
            c_slow <= c_slow + SLOW_ONE;
            c_fast <= c_fast + FAST_ONE;
        end
    end

    assign clk   = c_slow[SLOW_DIV_BIT];
    assign clk_2 = c_fast[FAST_DIV_BIT];

`ifdef CLKGEN_TICK_EN
    logic tick_slow_q;
    logic tick_fast_q;
    logic rst_next;

    // Value rst takes on this edge. Gating with it keeps a strobe from
    // appearing in the same cycle in which rst is still high.
    assign rst_next = rst_sync[RST_SYNC_STAGES-2];

    // The strobe is high in the cycle in which the counter reads 0 after a wrap.
    always_ff @(posedge osc_clk or negedge rstn) begin
        if (!rstn) begin
            tick_slow_q <= 1'b0;
            tick_fast_q <= 1'b0;
        end else begin
            tick_slow_q <= ~rst_next & (&c_slow);
            tick_fast_q <= ~rst_next & (&c_fast);
        end
    end

    assign tick_slow = tick_slow_q;
    assign tick_fast = tick_fast_q;
`else
    assign tick_slow = 1'b0;
    assign tick_fast = 1'b0;
`endif

endmodule

// File: tb/tb_osc_clock_reset_gen.sv
// ---------------------------------------------------------------------------
// tb_osc_clock_reset_gen
//   Self-checking bench. The small-divider instance is reset several times
//   at random points with random lengths, including sub-cycle glitches. Each
//   output is checked on every cycle against an edge-count reference model.
//   A second instance with the default dividers checks the long-period timing.
// ---------------------------------------------------------------------------
module tb_osc_clock_reset_gen;

    localparam int SD = 4;
    localparam int FD = 2;
    localparam int NS = 2;

    logic osc_clk  = 1'b0;
    logic rstn     = 1'b0;
    logic rstn_def = 1'b0;

    logic clk, clk_2, rst, tick_slow, tick_fast;
    logic clk_d, clk_2_d, rst_d, tick_slow_d, tick_fast_d;

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;   // osc_clk edges since the last reset release

    always #5 osc_clk = ~osc_clk;

    osc_clock_reset_gen #(
        .SLOW_DIV_BIT(SD),
        .FAST_DIV_BIT(FD),
        .RST_SYNC_STAGES(NS)
    ) dut (
        .osc_clk  (osc_clk),
        .rstn     (rstn),
        .clk      (clk),
        .clk_2    (clk_2),
        .rst      (rst),
        .tick_slow(tick_slow),
        .tick_fast(tick_fast)
    );

    osc_clock_reset_gen dut_def (
        .osc_clk  (osc_clk),
        .rstn     (rstn_def),
        .clk      (clk_d),
        .clk_2    (clk_2_d),
        .rst      (rst_d),
        .tick_slow(tick_slow_d),
        .tick_fast(tick_fast_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (n=%0d t=%0t)", tag, obs, exp, n, $time);
        end
    endtask

    // Reference model: a clock of period P is low for the first half of
    // each period, counted from release. A wrap strobe occurs every full
    // period once rst is low.
    function automatic logic half_hi(input int cnt, input int div_bit);
        return (cnt % (2 ** (div_bit + 1))) >= (2 ** div_bit);
    endfunction

    function automatic logic strobe(input int cnt, input int div_bit);
`ifdef CLKGEN_TICK_EN
        return (cnt > 0) && (cnt % (2 ** (div_bit + 1)) == 0) && (cnt >= NS);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_at(input int cnt);
        chk("rst",       rst,       cnt < NS);
        chk("clk",       clk,       half_hi(cnt, SD));
        chk("clk_2",     clk_2,     half_hi(cnt, FD));
        chk("tick_slow", tick_slow, strobe(cnt, SD));
        chk("tick_fast", tick_fast, strobe(cnt, FD));
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_rst"},   rst,       1'b1);
        chk({tag, "_clk"},   clk,       1'b0);
        chk({tag, "_clk_2"}, clk_2,     1'b0);
        chk({tag, "_ticks"}, {tick_slow, tick_fast}, 2'b00);
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge osc_clk);
            n++;
            #1;
            check_at(n);
        end
    endtask

    // Assert rstn between edges. A glitch releases it inside the same cycle.
    // Otherwise rstn is held for hold edges and released away from posedge.
    task automatic do_reset(input int hold, input bit glitch);
        @(posedge osc_clk);
        #($urandom_range(1, 5));
        rstn = 1'b0;
        #1;
        check_in_reset("async");
        if (glitch) begin
            #2;
            rstn = 1'b1;
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge osc_clk);
                #1;
                check_in_reset("hold");
            end
            @(negedge osc_clk);
            #($urandom_range(0, 3));
            rstn = 1'b1;
        end
        n = 0;
        check_at(0);
    endtask

    initial begin
        // Power-up: three cycles of reset, then release on a negedge.
        repeat (3) @(posedge osc_clk);
        #1;
        check_in_reset("por");
        @(negedge osc_clk);
        rstn = 1'b1;
        n = 0;
        check_at(0);

        // 212 edges stops inside the high phase of clk (212 % 32 = 20).
        run_cycles(212);
        chk("clk_hi_before_abort", clk, 1'b1);
        do_reset(2, 1'b0);
        run_cycles(40);

        for (int ep = 0; ep < 8; ep++) begin
            do_reset($urandom_range(1, 3), ($urandom_range(0, 3) == 0));
            run_cycles($urandom_range(1, 120));
        end

        // Default dividers: clk_2 toggles every 8192 edges and clk stays low.
        @(negedge osc_clk);
        rstn_def = 1'b1;
        for (int i = 1; i <= 32768; i++) begin
            @(posedge osc_clk);
            #1;
            if (i <= 4 || (i % 1024) == 0 || ((i + 1) % 8192) == 0) begin
                chk("def_rst",   rst_d,   i < 2);
                chk("def_clk_2", clk_2_d, ((i / 8192) % 2) == 1);
                chk("def_clk",   clk_d,   1'b0);
                chk("def_ticks", {tick_slow_d, tick_fast_d},
`ifdef CLKGEN_TICK_EN
                    {1'b0, (i % 16384) == 0});
`else
                    2'b00);
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
